// File: rtl/fft_frame_ctrl.sv
`timescale 1ns/1ps
// fft_frame_ctrl
//
// Frame sequencer for the 128-point radix-2 in-place FFT. It sits between
// the sample source and the butterfly / RAM / address-generator cluster.
// One frame is requested with `start`. The block then holds the address
// generator enable `ce` high for one fixed schedule, and `cnt` mirrors the
// generator's internal count. Every schedule-driven output is decoded
// from that count, so this block and the generator never disagree about
// where the frame is. The schedule never stalls.
//
// Frame schedule (cnt values while ce = 1):
//   0..127          load window, sample k accepted at cnt = k
//   2..129          load writes (ram_wsel = 0), sample k written at k+2
//   128..1023       butterfly reads, rd_stage = (cnt-128)/128
//   144..1039       butterfly writes (ram_wsel = 1), wr_stage = (cnt-144)/128
//   1025+RD_LAT ..  natural-order results on out_*, one per cycle
//     1152+RD_LAT
//   1153+RD_LAT     last ce cycle; DONE follows with ce = 0
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, ce = 0, cnt = 0
// LOAD  | accepting 128 input samples (cnt 0..127)
// COMPUTE | seven butterfly passes being read (cnt 128..1023)
// UNLOAD | draining butterfly writes, then streaming results out
// DONE  | one-cycle completion pulse, back to IDLE
//
// Parameters:
//   DW      width of each real / imaginary component
//   RD_LAT  cycles from a generator count value to valid ram_rdata
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-low reset
//   start      frame request, sampled only in IDLE
//   in_valid   input sample valid
//   in_ready   sample accepted this cycle
//   in_re/im   input sample components
//   ce         address generator enable, high for the whole frame
//   cnt        frame cycle counter (matches the generator's count)
//   ram_we     RAM write enable
//   ram_wsel   0 = write ram_wdata (load), 1 = write butterfly output
//   ram_wdata  {re,im} load data, two register stages behind the input
//   rd_stage   butterfly stage being read
//   wr_stage   butterfly stage being written
//   bf_en      butterfly datapath enable
//   ram_rdata  RAM read data
//   out_valid  result valid
//   out_data   result {re,im}
//   out_idx    result bin index
//   busy       frame active
//   done       one-cycle completion pulse
//   underrun   sticky missing-sample flag, cleared by an accepted start
//
// Build option:
//   FFT_FRAME_UNDERRUN_EN  when defined, a load slot with in_valid = 0 is
//                          written as zero and sets `underrun`. When it is
//                          undefined, samples are captured whenever
//                          in_ready = 1, in_valid is ignored, and
//                          `underrun` is tied 0.

module fft_frame_ctrl #(
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  output logic            ce,
  output logic [10:0]     cnt,
  output logic            ram_we,
  output logic            ram_wsel,
  output logic [2*DW-1:0] ram_wdata,
  output logic [2:0]      rd_stage,
  output logic [2:0]      wr_stage,
  output logic            bf_en,
  input  logic [2*DW-1:0] ram_rdata,
  output logic            out_valid,
  output logic [2*DW-1:0] out_data,
  output logic [6:0]      out_idx,
  output logic            busy,
  output logic            done,
  output logic            underrun
);

  localparam logic [10:0] LOAD_LAST   = 11'd127;
  localparam logic [10:0] LD_WR_FIRST = 11'd2;
  localparam logic [10:0] LD_WR_LAST  = 11'd129;
  localparam logic [10:0] BF_FIRST    = 11'd128;
  localparam logic [10:0] BF_LAST     = 11'd1023;
  localparam logic [10:0] BF_WR_FIRST = 11'd144;
  localparam logic [10:0] BF_WR_LAST  = 11'd1039;
  // Unload addresses are issued at cnt 1024..1151. Their data arrives
  // RD_LAT cycles later and is registered once more onto out_data.
  localparam logic [10:0] CAP_FIRST   = 11'(1024 + RD_LAT);
  localparam logic [10:0] CAP_LAST    = 11'(1151 + RD_LAT);
  localparam logic [10:0] FRAME_LAST  = 11'(1153 + RD_LAT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    UNLOAD,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ce_nxt;
  logic            cap;
  logic [2*DW-1:0] stage1;

  // ---------------------------------------------------------------------
  // State register and frame counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign ce_nxt = (state_nxt == LOAD) || (state_nxt == COMPUTE) ||
                  (state_nxt == UNLOAD);

  // cnt holds 0 on the first ce cycle and is back to 0 on the first cycle
  // after ce falls, matching an address generator that counts while
  // enabled and clears while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!ce_nxt) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= cnt + 11'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and schedule decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    ce        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    in_ready  = 1'b0;
    bf_en     = 1'b0;
    rd_stage  = 3'd0;
    wr_stage  = 3'd0;
    ram_we    = 1'b0;
    ram_wsel  = 1'b0;
    cap       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ce       = 1'b1;
        busy     = 1'b1;
        in_ready = 1'b1;
        if (cnt == LOAD_LAST) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        ce       = 1'b1;
        busy     = 1'b1;
        bf_en    = 1'b1;
        rd_stage = 3'((cnt - BF_FIRST) >> 7);
        if (cnt == BF_LAST) begin
          state_nxt = UNLOAD;
        end
      end
      UNLOAD: begin
        ce   = 1'b1;
        busy = 1'b1;
        cap  = (cnt >= CAP_FIRST) && (cnt <= CAP_LAST);
        if (cnt == FRAME_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Write windows straddle state boundaries: load writes run two cycles
    // into COMPUTE, and butterfly writes run 16 cycles into UNLOAD. They
    // are therefore decoded from cnt alone.
    if (ce) begin
      ram_wsel = (cnt >= BF_WR_FIRST) && (cnt <= BF_WR_LAST);
      ram_we   = ram_wsel || ((cnt >= LD_WR_FIRST) && (cnt <= LD_WR_LAST));
      if (ram_wsel) begin
        wr_stage = 3'((cnt - BF_WR_FIRST) >> 7);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Load data path: two register stages so sample k reaches ram_wdata at
  // cnt = k+2, in line with the generator's bit-reversed load address.
  // ---------------------------------------------------------------------
`ifdef FFT_FRAME_UNDERRUN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage1   <= '0;
      underrun <= 1'b0;
    end else begin
      if (in_ready) begin
        stage1 <= in_valid ? {in_re, in_im} : '0;
      end
      if ((state == IDLE) && start) begin
        underrun <= 1'b0;
      end else if (in_ready && !in_valid) begin
        underrun <= 1'b1;
      end
    end
  end
`else
  logic unused_in_valid;
  assign unused_in_valid = in_valid;
  assign underrun        = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage1 <= '0;
    end else if (in_ready) begin
      stage1 <= {in_re, in_im};
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wdata <= '0;
    end else begin
      ram_wdata <= stage1;
    end
  end

  // ---------------------------------------------------------------------
  // Result stream: registered copy of the RAM read port during unload.
  // Data and index are zeroed outside the burst so they are easy to read
  // in waveforms.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      out_valid <= cap;
      out_data  <= cap ? ram_rdata : '0;
      out_idx   <= cap ? 7'(cnt - CAP_FIRST) : 7'd0;
    end
  end

endmodule
